// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer
// Button-driven sequencer for the FP adder board flow. Each debounced press
// loads one switch byte (MSB first) into operand A, then operand B. The
// adder is then launched with a one-cycle start pulse. The block waits for
// the sum, or gives up after TIMEOUT cycles, and finally shows the sum one
// byte per press on the LEDs.
//
// Optional feature macro: LED_ECHO_EN. When it is defined, the LEDs show
// live switches in the load states instead of the one-hot byte index.
//
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   button        : debounced button level, synchronous to clk
//   sw[7:0]       : switch byte, written on a press in the load states
//   result[31:0]  : adder sum, valid while result_valid is high
//   result_valid  : one-cycle pulse from the adder
//   op_a, op_b    : operands to the adder
//   start         : one-cycle launch pulse
//   leds[7:0]     : display byte
//   state_code    : current state encoding
//   error         : high while in ERR
module fp_operand_sequencer #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic [7:0]  sw,
    input  logic [31:0] result,
    input  logic        result_valid,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        start,
    output logic [7:0]  leds,
    output logic [2:0]  state_code,
    output logic        error
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        SHOW   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [1:0]      idx, idx_n;
    logic [31:0]     op_a_n, op_b_n, res_q, res_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            btn_q;
    logic            press;
    logic [7:0]      leds_n;

    // Byte i addresses bits [31-8i -: 8], so index 0 is the MSB.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0: r[31:24] = b;
            2'd1: r[23:16] = b;
            2'd2: r[15:8]  = b;
            default: r[7:0] = b;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0: return w[31:24];
            2'd1: return w[23:16];
            2'd2: return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign press = button & ~btn_q;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        op_a_n  = op_a;
        op_b_n  = op_b;
        res_n   = res_q;
        cnt_n   = cnt;
        case (state)
            LOAD_A: if (press) begin
                op_a_n = put_byte(op_a, idx, sw);
                idx_n  = idx + 2'd1;
                if (idx == 2'd3) state_n = LOAD_B;
            end
            LOAD_B: if (press) begin
                op_b_n = put_byte(op_b, idx, sw);
                idx_n  = idx + 2'd1;
                if (idx == 2'd3) state_n = START;
            end
            START: begin
                cnt_n   = '0;
                idx_n   = 2'd0;
                state_n = WAIT;
            end
            WAIT: begin
                // A result on the terminal-count cycle still wins over timeout.
                if (result_valid) begin
                    res_n   = result;
                    idx_n   = 2'd0;
                    state_n = SHOW;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    idx_n   = 2'd0;
                    state_n = ERR;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHOW: if (press) begin
                idx_n = idx + 2'd1;
                if (idx == 2'd3) state_n = LOAD_A;
            end
            ERR: if (press) begin
                idx_n   = 2'd0;
                state_n = LOAD_A;
            end
            default: begin
                idx_n   = 2'd0;
                state_n = LOAD_A;
            end
        endcase

        // LEDs are registered, so they are built from the next-state view.
        leds_n = 8'h00;
        case (state_n)
`ifdef LED_ECHO_EN
            LOAD_A, LOAD_B: leds_n = sw;
`else
            LOAD_A, LOAD_B: leds_n = {4'b0000, 4'b0001 << idx_n};
`endif
            SHOW:    leds_n = get_byte(res_n, idx_n);
            ERR:     leds_n = 8'hFF;
            default: leds_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD_A;
            idx        <= 2'd0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
            cnt        <= '0;
            btn_q      <= button;   // held button through reset is not a press
            start      <= 1'b0;
            leds       <= 8'h01;
            state_code <= 3'd0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            op_a       <= op_a_n;
            op_b       <= op_b_n;
            res_q      <= res_n;
            cnt        <= cnt_n;
            btn_q      <= button;
            start      <= (state_n == START);
            leds       <= leds_n;
            state_code <= state_n;
            error      <= (state_n == ERR);
        end
    end
endmodule

// File: tb/tb_fp_operand_sequencer.sv
module tb_fp_operand_sequencer;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset, button, result_valid;
    logic [7:0]  sw;
    logic [31:0] result;
    logic [31:0] op_a, op_b;
    logic        start, error;
    logic [7:0]  leds;
    logic [2:0]  state_code;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    fp_operand_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .button(button), .sw(sw), .result(result),
        .result_valid(result_valid), .op_a(op_a), .op_b(op_b), .start(start),
        .leds(leds), .state_code(state_code), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phases plus plain press counters.
    // phase: 0 load, 1 start, 2 wait, 3 show, 4 err
    int          ph = 0;
    int          nload = 0;   // bytes loaded so far (0..8)
    int          wcyc = 0;    // cycles spent waiting
    int          shown = 0;   // show-phase presses
    bit          mprev = 0;
    logic [31:0] ma = 0, mb = 0, mr = 0;

    always @(posedge clk) begin
        bit p;
        if (reset) begin
            ph = 0; nload = 0; wcyc = 0; shown = 0;
            ma = 0; mb = 0; mr = 0; mprev = button;
        end else begin
            p = button && !mprev;
            mprev = button;
            case (ph)
                0: if (p) begin
                    if (nload < 4) ma[31 - 8*(nload % 4) -: 8] = sw;
                    else           mb[31 - 8*(nload % 4) -: 8] = sw;
                    nload++;
                    if (nload == 8) ph = 1;
                end
                1: begin ph = 2; wcyc = 0; end
                2: begin
                    wcyc++;
                    if (result_valid) begin mr = result; ph = 3; shown = 0; end
                    else if (wcyc == TO) ph = 4;
                end
                3: if (p) begin
                    shown++;
                    if (shown == 4) begin ph = 0; nload = 0; end
                end
                default: if (p) begin ph = 0; nload = 0; end
            endcase
        end
    end

    function automatic logic [7:0] m_leds();
        case (ph)
`ifdef LED_ECHO_EN
            0: return (nload == 0 && mprev == 0 && ma == 0 && mb == 0) ? 8'h00 : 8'h00;
`else
            0: return 8'(1 << (nload % 4));
`endif
            3: return mr[31 - 8*shown -: 8];
            4: return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

`ifdef LED_ECHO_EN
    logic [7:0] sw_at_edge;
    always @(posedge clk) sw_at_edge <= sw;
`endif

    always @(negedge clk) begin
        logic [7:0] el;
        if (chk_on) begin
            el = m_leds();
`ifdef LED_ECHO_EN
            if (ph == 0) el = sw_at_edge;
`endif
            chk("model_code",  {29'd0, state_code}, (ph == 0) ? nload / 4 : ph + 1);
            chk("model_leds",  {24'd0, leds}, {24'd0, el});
            chk("model_start", {31'd0, start}, {31'd0, ph == 1});
            chk("model_error", {31'd0, error}, {31'd0, ph == 4});
            chk("model_op_a",  op_a, ma);
            chk("model_op_b",  op_b, mb);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk); sw = b; button = 1'b1;
        @(negedge clk); button = 1'b0;
    endtask

    task automatic load8(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) push(a[31 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) push(b[31 - 8*i -: 8]);
    endtask

    initial begin
        reset = 1'b1; button = 1'b0; sw = 8'h00; result = '0; result_valid = 1'b0;
        tick(3);
        reset = 1'b0;
        chk_on = 1;
        tick(1);
        chk("rst_leds", {24'd0, leds}, 32'h01);
        chk("rst_code", {29'd0, state_code}, 32'd0);
        chk("rst_op_a", op_a, 32'h0);

        // Stray result_valid in a load state is ignored.
        @(negedge clk); result_valid = 1'b1; result = 32'h12345678;
        @(negedge clk); result_valid = 1'b0;

        // Normal run: 1.0 + 2.0
        load8(32'h3F800000, 32'h40000000);
        chk("start_pulse", {31'd0, start}, 32'd1);
        chk("lit_op_a", op_a, 32'h3F800000);
        chk("lit_op_b", op_b, 32'h40000000);
        tick(1);
        chk("start_drop", {31'd0, start}, 32'd0);
        tick(3);
        result_valid = 1'b1; result = 32'h40400000;
        tick(1);
        result_valid = 1'b0;
        chk("show_b0", {24'd0, leds}, 32'h40);
        chk("show_code", {29'd0, state_code}, 32'd4);
        push(8'h00); chk("show_b1", {24'd0, leds}, 32'h40);
        push(8'h00); chk("show_b2", {24'd0, leds}, 32'h00);
        push(8'h00); chk("show_b3", {24'd0, leds}, 32'h00);
        push(8'h00); chk("show_exit", {29'd0, state_code}, 32'd0);

        // Held button: exactly one byte
        @(negedge clk); sw = 8'hAA; button = 1'b1;
        tick(500);
        button = 1'b0;
        tick(1);
        chk("hold_op_a", op_a, 32'hAA800000);
        chk("hold_code", {29'd0, state_code}, 32'd0);
`ifndef LED_ECHO_EN
        chk("hold_idx1", {24'd0, leds}, 32'h02);
`endif
        push(8'h11);
`ifndef LED_ECHO_EN
        chk("idx2_onehot", {24'd0, leds}, 32'h04);
`endif
        push(8'h12); push(8'h34);
        chk("to_load_b", {29'd0, state_code}, 32'd1);
        sw = 8'hA5;
        tick(2);
`ifdef LED_ECHO_EN
        chk("echo_a5", {24'd0, leds}, 32'hA5);
`else
        chk("noecho_idx0", {24'd0, leds}, 32'h01);
`endif
        push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
        chk("lit_op_b2", op_b, 32'hA5010203);

        // Timeout; presses in WAIT are ignored
        push(8'h77);
        chk("wait_press", {29'd0, state_code}, 32'd3);
        tick(20);
        chk("err_code", {29'd0, state_code}, 32'd5);
        chk("err_flag", {31'd0, error}, 32'd1);
        chk("err_leds", {24'd0, leds}, 32'hFF);
        push(8'h00);
        chk("err_exit", {31'd0, error}, 32'd0);
        chk("err_exit_code", {29'd0, state_code}, 32'd0);

        // result_valid exactly on terminal count is accepted
        load8(32'h01020304, 32'h05060708);
        tick(16);
        result_valid = 1'b1; result = 32'hC0FFEE11;
        tick(1);
        result_valid = 1'b0;
        chk("tc_accept", {29'd0, state_code}, 32'd4);
        chk("tc_leds", {24'd0, leds}, 32'hC0);
        push(8'h00); push(8'h00); push(8'h00); push(8'h00);

        // Reset in WAIT, late result_valid, button held through reset
        load8(32'h11111111, 32'h22222222);
        tick(2);
        reset = 1'b1; button = 1'b1;
        tick(1);
        reset = 1'b0; result_valid = 1'b1; result = 32'hDEADBEEF;
        tick(1);
        result_valid = 1'b0;
        tick(3);
        button = 1'b0;
        tick(2);
        chk("rst2_code", {29'd0, state_code}, 32'd0);
        chk("rst2_op_a", op_a, 32'h0);
        chk("rst2_op_b", op_b, 32'h0);
        chk("rst2_leds", {24'd0, leds}, 32'h01);
        chk("rst2_start", {31'd0, start}, 32'd0);
        chk("rst2_error", {31'd0, error}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
